// File: rtl/wb_slave_access_ctrl.sv
// Wishbone access sequencer between the AHB bridge and the FPGA IP slaves: decodes the
// target, strobes one slave, and always completes the transfer (with a default on timeout).
module wb_slave_access_ctrl #(
  parameter int          NUM_SLV     = 3,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] DEF_RD_DAT  = 32'hFAB_DEF_AC
) (
  input  logic                    WB_CLK,
  input  logic                    WB_RST_n,
  input  logic [16:0]             WBs_ADR,
  input  logic                    WBs_CYC,
  input  logic                    WBs_STB,
  input  logic                    WBs_WE,
  output logic                    WBs_ACK,
  output logic [31:0]             WBs_RD_DAT,
  output logic [NUM_SLV-1:0]      slv_cyc_o,
  input  logic [NUM_SLV-1:0]      slv_ack_i,
  input  logic [32*NUM_SLV-1:0]   slv_rd_dat_i,
  output logic                    timeout_o,
  output logic [7:0]              err_cnt_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam logic [3:0] NUM_SLV_W = 4'(NUM_SLV);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [NUM_SLV-1:0]   cyc_q, cyc_d;
  logic                 ack_q, ack_d;
  logic [31:0]          rd_dat_q, rd_dat_d;
  logic                 tmo_q, tmo_d;
  logic [7:0]           err_q, err_d;

  logic [2:0]           idx;
  logic                 ack_sel;
  logic [31:0]          sel_dat;
  logic                 forced;
  logic                 forced_we;

  assign idx     = WBs_ADR[16:14];
  // The registered one-hot strobe doubles as the select, so stray acks are masked off.
  assign ack_sel = |(slv_ack_i & cyc_q);

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (cyc_q[i]) sel_dat = sel_dat | slv_rd_dat_i[32*i +: 32];
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    ack_d     = 1'b0;
    rd_dat_d  = '0;
    tmo_d     = 1'b0;
    err_d     = err_q;
    forced    = 1'b0;
    forced_we = we_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (WBs_CYC && WBs_STB) begin
          we_d = WBs_WE;
          if ({1'b0, idx} < NUM_SLV_W) begin
            state_d = ST_WAIT;
            for (int i = 0; i < NUM_SLV; i++) cyc_d[i] = (idx == 3'(i));
          end else begin
            state_d   = ST_DONE;
            forced    = 1'b1;
            forced_we = WBs_WE;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (!WBs_CYC) begin
          state_d = ST_IDLE;
          cyc_d   = '0;
        end else if (ack_sel) begin
          // Ack beats a timeout landing on the same edge.
          state_d  = ST_DONE;
          cyc_d    = '0;
          ack_d    = 1'b1;
          rd_dat_d = we_q ? 32'd0 : sel_dat;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = ST_DONE;
          cyc_d   = '0;
          forced  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
      end
    endcase

    if (forced) begin
      ack_d    = 1'b1;
      tmo_d    = 1'b1;
      rd_dat_d = forced_we ? 32'd0 : DEF_RD_DAT;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      cyc_q    <= '0;
      ack_q    <= 1'b0;
      rd_dat_q <= '0;
      tmo_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      cyc_q    <= cyc_d;
      ack_q    <= ack_d;
      rd_dat_q <= rd_dat_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  assign slv_cyc_o  = cyc_q;
  assign WBs_ACK    = ack_q;
  assign WBs_RD_DAT = rd_dat_q;
  assign timeout_o  = tmo_q;
  assign err_cnt_o  = err_q;

endmodule

// File: tb/tb_wb_slave_access_ctrl.sv
// Directed bench for wb_slave_access_ctrl: normal reads/writes, timeout, unmapped access,
// ack/timeout race, stray acks, bridge abort and mid-transfer reset.
module tb_wb_slave_access_ctrl;

  localparam int          NUM_SLV = 3;
  localparam int          TMO     = 8;
  localparam logic [31:0] DEF     = 32'hFABDEFAC;

  logic                  clk;
  logic                  rst_n;
  logic [16:0]           adr;
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic                  ack;
  logic [31:0]           rd_dat;
  logic [NUM_SLV-1:0]    slv_cyc;
  logic [NUM_SLV-1:0]    slv_ack;
  logic [32*NUM_SLV-1:0] slv_rd_dat;
  logic                  tmo;
  logic [7:0]            err_cnt;

  int checks   = 0;
  int failures = 0;
  int onehot_viol = 0;

  wb_slave_access_ctrl #(.NUM_SLV(NUM_SLV), .TIMEOUT_CYC(TMO), .DEF_RD_DAT(DEF)) dut (
    .WB_CLK       (clk),
    .WB_RST_n     (rst_n),
    .WBs_ADR      (adr),
    .WBs_CYC      (cyc),
    .WBs_STB      (stb),
    .WBs_WE       (we),
    .WBs_ACK      (ack),
    .WBs_RD_DAT   (rd_dat),
    .slv_cyc_o    (slv_cyc),
    .slv_ack_i    (slv_ack),
    .slv_rd_dat_i (slv_rd_dat),
    .timeout_o    (tmo),
    .err_cnt_o    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if ($countones(slv_cyc) > 1) onehot_viol++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start(input logic [16:0] a, input logic w);
    adr = a; we = w; cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic stop();
    cyc = 1'b0; stb = 1'b0;
  endtask

  initial begin
    int n;
    int saw_ack;
    int bad_cyc;
    int miss;

    rst_n = 1'b0; adr = '0; cyc = 1'b0; stb = 1'b0; we = 1'b0; slv_ack = '0;
    slv_rd_dat = {32'hBBBB2222, 32'h12345678, 32'hAAAA0000};
    tick(); tick();
    check("rst_ack",     32'(ack),     32'd0);
    check("rst_cyc",     32'(slv_cyc), 32'd0);
    check("rst_rd_dat",  rd_dat,       32'd0);
    check("rst_tmo",     32'(tmo),     32'd0);
    check("rst_err",     32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Read slave 1, ack after two strobe cycles
    start(17'h04010, 1'b0);
    tick();
    check("t1_cyc_c1", 32'(slv_cyc), 32'b010);
    check("t1_ack_c1", 32'(ack),     32'd0);
    tick();
    check("t1_cyc_c2", 32'(slv_cyc), 32'b010);
    slv_ack = 3'b010;
    tick();
    check("t1_ack",    32'(ack),     32'd1);
    check("t1_rd_dat", rd_dat,       32'h12345678);
    check("t1_cyc_off",32'(slv_cyc), 32'd0);
    check("t1_tmo",    32'(tmo),     32'd0);
    slv_ack = '0; stop();
    tick();
    check("t1_ack_1cyc", 32'(ack), 32'd0);
    check("t1_rd_clr",   rd_dat,   32'd0);

    // Write slave 0, immediate ack
    start(17'h00000, 1'b1);
    tick();
    check("t2_cyc", 32'(slv_cyc), 32'b001);
    check("t2_ack_early", 32'(ack), 32'd0);
    slv_ack = 3'b001;
    tick();
    check("t2_ack",    32'(ack),     32'd1);
    check("t2_rd_dat", rd_dat,       32'd0);
    check("t2_err",    32'(err_cnt), 32'd0);
    slv_ack = '0; stop();
    tick();

    // Read slave 2, never acked: timeout after TMO wait cycles
    start(17'h08000, 1'b0);
    n = 0;
    for (int i = 0; i < 20 && ack !== 1'b1; i++) begin
      tick();
      if (slv_cyc == 3'b100) n++;
    end
    check("t3_ack",     32'(ack),     32'd1);
    check("t3_waits",   32'(n),       32'(TMO));
    check("t3_rd_dat",  rd_dat,       DEF);
    check("t3_tmo",     32'(tmo),     32'd1);
    check("t3_err",     32'(err_cnt), 32'd1);
    stop();
    tick();
    check("t3_tmo_pulse", 32'(tmo), 32'd0);

    // Ack while idle is ignored
    slv_ack = 3'b010;
    tick();
    check("t5_idle_ack", 32'(ack), 32'd0);
    slv_ack = '0;

    // Slave-1 access with stray slave-0 ack, real ack on the timeout edge
    start(17'h04010, 1'b0);
    slv_ack = 3'b001;
    saw_ack = 0; bad_cyc = 0;
    for (int i = 0; i < TMO; i++) begin
      tick();
      if (ack) saw_ack++;
      if (slv_cyc != 3'b010) bad_cyc++;
    end
    check("t5_stray_ack", 32'(saw_ack), 32'd0);
    check("t5_cyc_held",  32'(bad_cyc), 32'd0);
    slv_ack = 3'b011;
    tick();
    check("t5_ack",    32'(ack),     32'd1);
    check("t5_rd_dat", rd_dat,       32'h12345678);
    check("t5_tmo",    32'(tmo),     32'd0);
    check("t5_err",    32'(err_cnt), 32'd1);
    slv_ack = '0; stop();
    tick();

    // Bridge abort mid-wait
    start(17'h00000, 1'b0);
    tick(); tick();
    check("t6_cyc", 32'(slv_cyc), 32'b001);
    stop();
    tick();
    check("t6_cyc_clr",  32'(slv_cyc), 32'd0);
    check("t6_no_ack",   32'(ack),     32'd0);
    tick();
    check("t6_no_ack2",  32'(ack),     32'd0);
    check("t6_err",      32'(err_cnt), 32'd1);

    // Reset mid-wait is asynchronous
    start(17'h08000, 1'b0);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_cyc", 32'(slv_cyc), 32'd0);
    check("t6_rst_err", 32'(err_cnt), 32'd0);
    check("t6_rst_ack", 32'(ack),     32'd0);
    stop();
    tick();
    rst_n = 1'b1;
    tick();
    start(17'h04010, 1'b0);
    tick();
    slv_ack = 3'b010;
    tick();
    check("t6_post_ack",    32'(ack), 32'd1);
    check("t6_post_rd_dat", rd_dat,   32'h12345678);
    slv_ack = '0; stop();
    tick();

    // Unmapped accesses: write to idx 3, then reads to idx 7 until saturation
    start(17'h0C000, 1'b1);
    tick();
    check("t4_w_ack",    32'(ack),     32'd1);
    check("t4_w_rd_dat", rd_dat,       32'd0);
    check("t4_w_tmo",    32'(tmo),     32'd1);
    check("t4_w_cyc",    32'(slv_cyc), 32'd0);
    check("t4_w_err",    32'(err_cnt), 32'd1);
    stop();
    tick();
    start(17'h1C000, 1'b0);
    tick();
    check("t4_r_ack",    32'(ack),     32'd1);
    check("t4_r_rd_dat", rd_dat,       DEF);
    check("t4_r_err",    32'(err_cnt), 32'd2);
    stop();
    tick();
    miss = 0; bad_cyc = 0;
    for (int i = 0; i < 299; i++) begin
      start(17'h1C000, 1'b0);
      tick();
      if (ack !== 1'b1) miss++;
      if (slv_cyc != '0) bad_cyc++;
      stop();
      tick();
    end
    check("t4_loop_ack", 32'(miss),    32'd0);
    check("t4_loop_cyc", 32'(bad_cyc), 32'd0);
    check("t4_err_sat",  32'(err_cnt), 32'hFF);

    check("onehot", 32'(onehot_viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
